// File: rtl/lsu_mem_port_if.sv
// Request/response and memory-side signals of the load/store unit.
// The slave modport is the LSU; the master modport is the execute stage plus memory.
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit in front of a word-wide memory: sub-word stores by read-modify-write,
// sign/zero-extended loads. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module lsu_mem_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    lsu_mem_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              req_illegal;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;
    logic              is_sw;

    assign is_sw = we_q && (f3_q == 3'b010);

    always_comb begin
        req_illegal = 1'b0;
        case (bus.req_funct3)
            3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
            3'b100, 3'b101:         req_illegal = bus.req_we;
            default:                req_illegal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            req_illegal = 1'b1;
        if (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00)
            req_illegal = 1'b1;
`endif
    end

    // Lane selection uses only the low address bits, so H/W ignore misaligned bits naturally.
    always_comb begin
        lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_ext = {{(DATA_W-8){lane_b[7]}}, lane_b};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, lane_b};
            3'b001:  load_ext = {{(DATA_W-16){lane_h[15]}}, lane_h};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, lane_h};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merged = bus.mem_rdata;
        if (f3_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = req_illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (is_sw) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = wdata_q;
                    state_nxt     = RESP;
                end else begin
                    state_nxt = we_q ? WRITE : RESP;
                end
            end
            WRITE: begin
                bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus.mem_we    = 1'b1;
                bus.mem_wdata = merge_q;
                state_nxt     = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    f3_q    <= bus.req_funct3;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    if (req_illegal) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : load_ext;
                    err_q   <= 1'b0;
                    if (we_q)
                        merge_q <= merged;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a driver queues expected responses, a negedge
// monitor pops and compares them, and a word-array memory model sits on the mem port.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus();
    lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [16];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int last_we_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: memory-write bookkeeping and response scoreboard.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            check("mem_addr_aligned", {30'b0, bus.mem_addr[1:0]}, 32'd0);
        end
        if (bus.resp_valid) begin
            check("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                check({e.name, "_err"}, 32'(bus.resp_err), 32'(e.err));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // lat is counted in cycles after the request cycle T (accept edge ends cycle T).
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input logic expect_resp, output int t);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        t = cyc;
        if (expect_resp) begin
            e = '{name, exp_rdata, exp_err, t + lat};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int t;
        int w0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b0;

        // Word round-trip
        w0 = we_cnt;
        issue("sw8", 1'b1, 3'b010, 32'h8, 32'h12345678, 32'h0, 1'b0, 2, 1'b1, t);
        drain();
        check("sw8_we_count", 32'(we_cnt - w0), 32'd1);
        check("sw8_we_cycle", 32'(last_we_cyc), 32'(t + 1));
        check("sw8_mem", mem[2], 32'h12345678);
        issue("lw8", 1'b0, 3'b010, 32'h8, 32'h0, 32'h12345678, 1'b0, 2, 1'b1, t);

        // Load extension
        issue("sw4", 1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, t);
        issue("lb7", 1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b1, t);
        issue("lbu7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h000000DE, 1'b0, 2, 1'b1, t);
        issue("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1'b1, t);
        issue("lhu4", 1'b0, 3'b101, 32'h4, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1, t);
        issue("lbu5", 1'b0, 3'b100, 32'h5, 32'h0, 32'h000000BE, 1'b0, 2, 1'b1, t);
        issue("lb4", 1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 1'b1, t);
        drain();

        // Misaligned load
        w0 = we_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
        issue("lw6_mis", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 1'b1, t);
`else
        issue("lw6_mis", 1'b0, 3'b010, 32'h6, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, t);
`endif
        drain();
        check("lw6_we_count", 32'(we_cnt - w0), 32'd0);

        // SB read-modify-write
        w0 = we_cnt;
        issue("sb5", 1'b1, 3'b000, 32'h5, 32'h000000AA, 32'h0, 1'b0, 3, 1'b1, t);
        drain();
        check("sb5_we_count", 32'(we_cnt - w0), 32'd1);
        check("sb5_we_cycle", 32'(last_we_cyc), 32'(t + 2));
        check("sb5_mem", mem[1], 32'hDEADAAEF);
        issue("lw4_after_sb", 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADAAEF, 1'b0, 2, 1'b1, t);

        // SH upper half; only the low 16 bits of wdata may land
        issue("sh6", 1'b1, 3'b001, 32'h6, 32'hFFFFCAFE, 32'h0, 1'b0, 3, 1'b1, t);
        drain();
        check("sh6_mem", mem[1], 32'hCAFEAAEF);

        // Illegal funct3
        w0 = we_cnt;
        issue("sbu_illegal", 1'b1, 3'b100, 32'h4, 32'h00000055, 32'h0, 1'b1, 1, 1'b1, t);
        issue("f3_011", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1, 1'b1, t);
        drain();
        check("illegal_we_count", 32'(we_cnt - w0), 32'd0);
        check("illegal_mem", mem[1], 32'hCAFEAAEF);

        // Reset during WRITE of SH
        issue("sw4_restore", 1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, t);
        drain();
        issue("sh4_rst", 1'b1, 3'b001, 32'h4, 32'h00001234, 32'h0, 1'b0, 3, 1'b0, t);
        @(posedge clk);
        #2;
        check("sh4_write_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("sh4_we_async_drop", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_mem", mem[1], 32'hDEADBEEF);
        issue("lw4_post_rst", 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, t);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
